uart_rx_byte: RTL

UART serial receiver that deserializes one asynchronous RX line into 8-bit bytes. It feeds the byte-to-word packing FIFO directly. `data_out` connects to FIFO `data_in`, `data_valid` connects to FIFO `wr_en`, and FIFO `full` is returned on `fifo_full`. The receiver samples the line with a 16x-oversampled baud tick, validates start, stop and (optionally) parity bits, and reports framing, parity and overrun errors as one-cycle pulses.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_rx_byte.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor helper, line idle level.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam logic UART_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_rx_state_t;

    // Clocks per oversample tick, truncated.
    function automatic int unsigned uart_baud_div(input int unsigned clk_freq,
                                                  input int unsigned baud,
                                                  input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Divisor counter producing a one-cycle tick every DIV clocks; synchronous clear restarts the phase.
module uart_baud_gen #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Free-running divide counter, held at zero while cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CW'(DIV - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver with 16x oversampling, framing/overrun checks and optional even parity.
// Optional feature macro: UART_RX_PARITY_EN (start, data, even parity, stop framing).
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 fifo_full,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned DIV  = uart_baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned TW   = $clog2(OVERSAMPLE);
    localparam int unsigned BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned HALF = OVERSAMPLE / 2;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    uart_rx_state_t       r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic                 r_overrun_err;
    logic                 r_busy;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_err;
    logic                 r_parity_err;
`endif

    logic w_tick;
    logic w_start_edge;
    logic w_baud_clr;
    logic w_bit_end;
    logic w_half_bit;

    assign w_start_edge = r_rx_prev & ~r_rx_s;
    assign w_baud_clr   = (r_state == ST_IDLE);
    assign w_bit_end    = w_tick && (r_tick_cnt == TW'(OVERSAMPLE - 1));
    assign w_half_bit   = w_tick && (r_tick_cnt == TW'(HALF - 1));

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_baud_clr),
        .o_tick (w_tick)
    );

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= UART_IDLE;
            r_rx_s    <= UART_IDLE;
            r_rx_prev <= UART_IDLE;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // Frame FSM: samples mid-bit, resolves the stop bit into exactly one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_tick_cnt    <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err     <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_tick_cnt <= '0;
                    r_bit_idx  <= '0;
`ifdef UART_RX_PARITY_EN
                    r_par_err  <= 1'b0;
`endif
                    if (w_start_edge) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_half_bit) begin
                        r_tick_cnt <= '0;
                        if (r_rx_s != UART_IDLE) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == BW'(DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= ST_PARITY;
`else
                            r_state   <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                        end
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tick_cnt <= '0;
                        r_par_err  <= ^{r_shift, r_rx_s};
                        r_state    <= ST_STOP;
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_tick_cnt <= '0;
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        if (r_rx_s != UART_IDLE) begin
                            r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_err) begin
                            r_parity_err <= 1'b1;
`endif
                        end else if (fifo_full) begin
                            r_overrun_err <= 1'b1;
                        end else begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = r_parity_err;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
